// File: rtl/adda_sample_pipe_if.sv
// Sample-path bus between the converter-facing top level and adda_sample_pipe.
// The slave side is the pipeline; the master side drives ADC data and controls.
interface adda_sample_pipe_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_DELAY = 16
);
    localparam int DELAY_W = $clog2(MAX_DELAY);

    logic [DATA_W-1:0]  i_ad_data;
    logic [1:0]         i_mode;
    logic [DELAY_W-1:0] i_delay;
    logic               i_hold;
    logic               i_clip_clr;
    logic [DATA_W-1:0]  o_da_data;
    logic [DATA_W-1:0]  o_peak;
    logic               o_clip;

    modport master (
        output i_ad_data, i_mode, i_delay, i_hold, i_clip_clr,
        input  o_da_data, o_peak, o_clip
    );

    modport slave (
        input  i_ad_data, i_mode, i_delay, i_hold, i_clip_clr,
        output o_da_data, o_peak, o_clip
    );
endinterface

// File: rtl/adda_sample_pipe.sv
// ADC-to-DAC sample pipeline: input register, programmable delay line,
// output mode selector, windowed peak meter and sticky clip flag.
// Samples are offset-binary; midscale is the 0 V code.
module adda_sample_pipe #(
    parameter int DATA_W    = 8,
    parameter int MAX_DELAY = 16,
    parameter int PEAK_LOG2 = 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    adda_sample_pipe_if.slave bus
);
    localparam int DELAY_W = $clog2(MAX_DELAY);
    localparam logic [DATA_W-1:0]  MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  FULL     = {DATA_W{1'b1}};
    localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(MAX_DELAY - 1);

    // s1_vld stays low for the first edge after reset, while s1 still holds
    // its midscale reset value, so that value cannot count as a captured
    // sample for the peak meter or the clip flag.
    logic [DATA_W-1:0]    s1;
    logic                 s1_vld;
    logic [DATA_W-1:0]    dly_mem [MAX_DELAY];
    logic [DELAY_W-1:0]   wptr;
    logic [DELAY_W-1:0]   fill;
    logic [DELAY_W-1:0]   rptr;
    logic [DATA_W-1:0]    tap;
    logic [DATA_W-1:0]    sel;
    logic [DATA_W-1:0]    ramp;
    logic [DATA_W-1:0]    trk;
    logic [DATA_W-1:0]    peak_in;
    logic [DATA_W-1:0]    peak_max;
    logic [PEAK_LOG2-1:0] wcnt;
    logic [DATA_W-1:0]    da_q;
    logic [DATA_W-1:0]    peak_q;
    logic                 clip_q;

    assign rptr = wptr - bus.i_delay;

    // Input register, write pointer and fill count for the delay line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1     <= MID;
            s1_vld <= 1'b0;
            wptr   <= '0;
            fill   <= '0;
        end else begin
            s1     <= bus.i_ad_data;
            s1_vld <= 1'b1;
            wptr   <= wptr + 1'b1;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Delay-line storage; unwritten entries are masked by the fill count,
    // so the array needs no reset.
    always_ff @(posedge i_clk) begin
        dly_mem[wptr] <= s1;
    end

    // Read tap: bypass for zero delay, midscale until enough history exists.
    always_comb begin
        tap = MID;
        if (bus.i_delay == '0) begin
            tap = s1;
        end else if (fill >= bus.i_delay) begin
            tap = dly_mem[rptr];
        end
    end

    // Output mode selector feeding the DAC register.
    always_comb begin
        sel = MID;
        case (bus.i_mode)
            2'd0:    sel = tap;
            2'd1:    sel = FULL - tap;
            2'd2:    sel = ramp;
            default: sel = MID;
        endcase
    end

    // DAC output register with hold, plus the free-running test ramp.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            da_q <= MID;
            ramp <= '0;
        end else begin
            ramp <= ramp + 1'b1;
            if (!bus.i_hold) begin
                da_q <= sel;
            end
        end
    end

    assign peak_in  = s1_vld ? s1 : '0;
    assign peak_max = (peak_in > trk) ? peak_in : trk;

    // Peak meter: track the running maximum and publish it when the
    // window counter wraps.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wcnt   <= '0;
            trk    <= '0;
            peak_q <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) begin
                peak_q <= peak_max;
                trk    <= '0;
            end else begin
                trk <= peak_max;
            end
        end
    end

    // Sticky clip flag; a rail sample beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clip_q <= 1'b0;
        end else if (s1_vld && (s1 == '0 || s1 == FULL)) begin
            clip_q <= 1'b1;
        end else if (bus.i_clip_clr) begin
            clip_q <= 1'b0;
        end
    end

    assign bus.o_da_data = da_q;
    assign bus.o_peak    = peak_q;
    assign bus.o_clip    = clip_q;
endmodule

// File: tb/tb_adda_sample_pipe.sv
// Bench for adda_sample_pipe: a cycle-level reference model built from the
// sample history checks all outputs every cycle; directed sequences add
// hand-computed literal expectations.
module tb_adda_sample_pipe;
    localparam logic [7:0] MID = 8'h80;

    logic clk = 1'b0;
    logic i_reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    adda_sample_pipe_if #(.DATA_W(8), .MAX_DELAY(16)) bus ();

    adda_sample_pipe #(.DATA_W(8), .MAX_DELAY(16), .PEAK_LOG2(4)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // Reference model state.
    logic [7:0] m_s1;
    bit         m_s1v;
    logic [7:0] m_hist[$];
    logic [7:0] m_out;
    logic [7:0] m_peak;
    logic [7:0] m_trk;
    logic [7:0] m_ramp;
    bit         m_clip;
    int         m_cyc;
    logic [7:0] m_tap;
    logic [7:0] m_smp;
    int         m_d;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: the DAC sees the captured sample from d edges ago (midscale
    // while the history is shorter than d), peak is the max of captured
    // samples per 16-edge window, clip is sticky on rail codes.
    always @(posedge clk) begin
        if (i_reset) begin
            m_s1 = MID; m_s1v = 0; m_hist.delete();
            m_out = MID; m_peak = 0; m_trk = 0; m_ramp = 0; m_clip = 0; m_cyc = 0;
        end else begin
            m_d = int'(bus.i_delay);
            if (m_d == 0) m_tap = m_s1;
            else if (m_hist.size() < m_d) m_tap = MID;
            else m_tap = m_hist[m_hist.size() - m_d];
            if (!bus.i_hold) begin
                case (bus.i_mode)
                    2'd0: m_out = m_tap;
                    2'd1: m_out = 8'd255 - m_tap;
                    2'd2: m_out = m_ramp;
                    default: m_out = MID;
                endcase
            end
            m_ramp = m_ramp + 8'd1;
            m_smp = m_s1v ? m_s1 : 8'd0;
            if (m_smp > m_trk) m_trk = m_smp;
            if (m_cyc % 16 == 15) begin
                m_peak = m_trk;
                m_trk = 0;
            end
            if (m_s1v && (m_s1 == 8'h00 || m_s1 == 8'hFF)) m_clip = 1;
            else if (bus.i_clip_clr) m_clip = 0;
            m_hist.push_back(m_s1);
            if (m_hist.size() > 32) void'(m_hist.pop_front());
            m_s1 = bus.i_ad_data;
            m_s1v = 1;
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_da", bus.o_da_data, m_out);
            check("model_peak", bus.o_peak, m_peak);
            check("model_clip", bus.o_clip, m_clip);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        bus.i_ad_data = 8'h10; bus.i_mode = 2'd0; bus.i_delay = '0;
        bus.i_hold = 1'b0; bus.i_clip_clr = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_da", bus.o_da_data, 8'h80);
        check("reset_peak", bus.o_peak, 8'h00);
        check("reset_clip", bus.o_clip, 1'b0);

        // Mode 0, d=0: two-edge latency.
        i_reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            bus.i_ad_data = 8'(8'h10 + k - 1);
            step();
            if (k == 1) check("d0_first", bus.o_da_data, 8'h80);
            if (k == 2) check("d0_lat2", bus.o_da_data, 8'h10);
            if (k == 3) check("d0_next", bus.o_da_data, 8'h11);
        end

        // Mode 0, d=5 from reset, then d 5->2 mid-stream.
        bus.i_delay = 4'd5;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            bus.i_ad_data = 8'(8'h10 + k - 1);
            if (k == 9) bus.i_delay = 4'd2;
            step();
            if (k == 6) check("d5_fill_mid", bus.o_da_data, 8'h80);
            if (k == 7) check("d5_lat7", bus.o_da_data, 8'h10);
            if (k == 8) check("d5_next", bus.o_da_data, 8'h11);
            if (k == 9) check("d5to2_jump", bus.o_da_data, 8'h15);
        end

        // Mode 1 invert, mode 3 midscale.
        bus.i_delay = '0; bus.i_mode = 2'd1; bus.i_ad_data = 8'h30;
        repeat (3) step();
        check("invert_30", bus.o_da_data, 8'hCF);
        bus.i_mode = 2'd3;
        repeat (2) step();
        check("midscale", bus.o_da_data, 8'h80);

        // Mode 2 ramp from reset, including wrap.
        bus.i_mode = 2'd2; bus.i_ad_data = 8'h20;
        do_reset();
        for (int k = 1; k <= 258; k++) begin
            step();
            if (k == 1) check("ramp_start", bus.o_da_data, 8'h00);
            if (k == 100) check("ramp_mid", bus.o_da_data, 8'd99);
            if (k == 256) check("ramp_ff", bus.o_da_data, 8'hFF);
            if (k == 257) check("ramp_wrap", bus.o_da_data, 8'h00);
        end

        // Hold for 10 cycles with changing input.
        bus.i_mode = 2'd0;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            bus.i_ad_data = 8'(8'h40 + k - 1);
            bus.i_hold = (k >= 5 && k <= 14);
            step();
            if (k == 4) check("pre_hold", bus.o_da_data, 8'h42);
            if (k == 14) check("held", bus.o_da_data, 8'h42);
            if (k == 15) check("hold_release", bus.o_da_data, 8'h4D);
        end
        bus.i_hold = 1'b0;

        // Peak meter with 16-cycle windows.
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            bus.i_ad_data = (k == 7) ? 8'h9A : 8'h20;
            step();
            if (k == 15) check("peak_pre", bus.o_peak, 8'h00);
            if (k == 16) check("peak_win1", bus.o_peak, 8'h9A);
            if (k == 31) check("peak_hold", bus.o_peak, 8'h9A);
            if (k == 32) check("peak_win2", bus.o_peak, 8'h20);
        end

        // Clip: set, stay, clear, set-wins-over-clear.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            bus.i_ad_data = (k == 3) ? 8'hFF : ((k == 10) ? 8'h00 : 8'h50);
            bus.i_clip_clr = (k == 9 || k == 11 || k == 12);
            step();
            if (k == 3) check("clip_clean", bus.o_clip, 1'b0);
            if (k == 4) check("clip_set", bus.o_clip, 1'b1);
            if (k == 8) check("clip_sticky", bus.o_clip, 1'b1);
            if (k == 9) check("clip_clr", bus.o_clip, 1'b0);
            if (k == 11) check("clip_set_wins", bus.o_clip, 1'b1);
            if (k == 12) check("clip_clr2", bus.o_clip, 1'b0);
        end
        bus.i_clip_clr = 1'b0;
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adda_sample_pipe.md
Name: adda_sample_pipe

Overview:
- Parametrised ADC-to-DAC sample pipeline between the AD9280 capture port and the AD9708 output port on the J2 add-on.
- Registers each ADC sample and passes it through a programmable delay line and an output mode selector to the DAC.
- Adds a windowed peak meter for the LEDs and a sticky clip flag, which the plain loopback path lacks.
- Converter clock pins stay in the top level; this block is purely synchronous to i_clk.

Parameters:
- DATA_W, 8: sample width, ADC and DAC, offset-binary.
- MAX_DELAY, 16: delay-line entries; power of two, >=2.
- PEAK_LOG2, 20: peak window length is 2^PEAK_LOG2 cycles (about 42 ms at 25 MHz).
- DELAY_W, clog2(MAX_DELAY): localparam, width of i_delay.

Ports:
- i_clk, in, 1: system clock (25 MHz); all logic on the rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_ad_data, in, DATA_W: raw ADC sample bus, stable at the rising edge.
- i_mode, in, 2: 0 pass, 1 invert, 2 ramp, 3 midscale.
- i_delay, in, DELAY_W: extra delay in cycles, 0..MAX_DELAY-1.
- i_hold, in, 1: freeze DAC output register.
- i_clip_clr, in, 1: clear sticky clip flag.
- o_da_data, out, DATA_W: registered DAC sample.
- o_peak, out, DATA_W: maximum sample of the last completed window (LED drive).
- o_clip, out, 1: sticky; set when any captured sample is 0 or 2^DATA_W-1.

Behaviour:
- Reset values:
  - o_da_data = 2^(DATA_W-1) (midscale, 0 V); o_peak = 0; o_clip = 0.
  - Write pointer, fill count, ramp counter and window counter = 0; peak tracker = 0.
- Stage 1: s1 <= i_ad_data every cycle, including during hold.
- Delay line:
  - Circular buffer of MAX_DELAY entries; s1 is written at wptr every cycle; wptr increments mod MAX_DELAY.
  - Read tap d = i_delay, taken combinationally each cycle. For d=0 the tap is s1 (bypass). For d>0 the tap is buf[(wptr-d) mod MAX_DELAY], i.e. the value s1 held d cycles earlier.
  - fill counts entries written since reset and saturates at MAX_DELAY-1. While fill < d, the tap returns midscale instead of stale RAM.
  - Changing i_delay takes effect on the next cycle. No flush; a discontinuity at the output is permitted.
- Stage 2 (output register), unless i_hold:
  - mode 0: tap.
  - mode 1: (2^DATA_W-1) - tap.
  - mode 2: ramp counter value. The counter increments every cycle regardless of mode and hold, and wraps 2^DATA_W-1 -> 0.
  - mode 3: 2^(DATA_W-1).
- Hold: o_da_data keeps its value. The delay line, ramp, peak meter and clip logic keep running. On release, the next cycle loads the current selection.
- Latency: i_ad_data to o_da_data is 2 + i_delay cycles in modes 0/1.
- Peak meter:
  - Operates on s1; the window counter is PEAK_LOG2 bits and free-running.
  - Each cycle, tracker <= max(tracker, s1).
  - On the cycle the counter equals all-ones: o_peak <= max(tracker, s1) and tracker <= 0. Window boundaries wrap naturally.
- Clip:
  - If s1 == 0 or s1 == all-ones, o_clip <= 1.
  - Else if i_clip_clr, o_clip <= 0.
  - A set and a clear in the same cycle: set wins.
- Mode changes act on the next stage-2 load; i_mode is not latched elsewhere.
- Reset mid-operation:
  - All state returns to its reset value on the next edge; buffer contents need not be cleared, because the fill gating hides them.
  - The first post-reset sample reaches o_da_data 2 cycles after the first non-reset edge, for d=0.

Test Plan:
- Reset, mode 0, d=0, drive i_ad_data 0x10,0x11,0x12,... one per cycle -> o_da_data shows 0x80 until the 2nd edge after reset release, then 0x10,0x11,... with 2-cycle latency.
- Mode 0, d=5, same ramp input -> the first 5 post-fill outputs are 0x80, then 0x10 appears 7 cycles after input; change d 5->2 mid-stream -> output jumps forward 3 samples the next cycle.
- Mode 1 with input 0x30 -> 0xCF. Mode 2 -> o_da_data increments by 1 per cycle and wraps 0xFF->0x00. Mode 3 -> constant 0x80.
- Mode 0, assert i_hold for 10 cycles with changing input -> o_da_data frozen. Release -> the correctly delayed current sample appears on the next cycle.
- PEAK_LOG2=4, input 0x20 except a single 0x9A in cycle 7 -> o_peak = 0x9A after window 1; next window all 0x20 -> o_peak = 0x20.
- Input 0xFF for 1 cycle -> o_clip = 1 and stays set. i_clip_clr with clean input -> 0. i_clip_clr in the same cycle as a 0x00 input -> o_clip remains 1.
